// File: rtl/cn_list_feeder.sv
// Buffers two sorted (LLR, Q) lists loaded serially and replays them into the
// A and I write ports of a check node, honouring A_ready/I_ready back-pressure.
module cn_list_feeder #(
   parameter int LLR_Width     = 6,
   parameter int Q_Width       = 5,
   parameter int Counter_Width = 4,
   parameter int Depth         = 2**(Counter_Width+1)-1
) (
   input  logic                 clk,
   input  logic                 force_reset_n,
   input  logic                 load_en,
   input  logic                 load_sel,
   input  logic [LLR_Width:0]   load_llr,
   input  logic [Q_Width:0]     load_q,
   input  logic                 start,
   input  logic                 A_ready,
   input  logic                 I_ready,
   output logic                 write_A,
   output logic [LLR_Width:0]   Out_LLR_A,
   output logic [Q_Width:0]     Out_Q_A,
   output logic                 write_I,
   output logic [LLR_Width:0]   Out_LLR_I,
   output logic [Q_Width:0]     Out_Q_I,
   output logic                 busy,
   output logic                 done,
   output logic                 load_err,
   output logic                 sort_err
);

   localparam int            CW   = Counter_Width + 1;
   localparam logic [CW-1:0] FULL = CW'(Depth);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state;

   logic [LLR_Width:0] mem_llr_a [Depth];
   logic [Q_Width:0]   mem_q_a   [Depth];
   logic [LLR_Width:0] mem_llr_i [Depth];
   logic [Q_Width:0]   mem_q_i   [Depth];

   logic [CW-1:0]      cnt_a, cnt_i, rd_a, rd_i;
   logic [LLR_Width:0] prev_a, prev_i;

   logic accept, full_a, full_i, load_a, load_i, drop, misorder;
   logic more_a, more_i, stream_end;

   always_comb begin
      accept   = (state == IDLE) && load_en;
      full_a   = (cnt_a == FULL);
      full_i   = (cnt_i == FULL);
      load_a   = accept && !load_sel && !full_a;
      load_i   = accept &&  load_sel && !full_i;
      drop     = accept && (load_sel ? full_i : full_a);
      // Trackers start at zero, so an unsigned first entry can never misorder.
      misorder = (load_a && (load_llr < prev_a)) ||
                 (load_i && (load_llr < prev_i));

      more_a     = (rd_a < cnt_a);
      more_i     = (rd_i < cnt_i);
      stream_end = (!more_a || A_ready) && (!more_i || I_ready);

      write_A   = (state == STREAM) && more_a && !A_ready;
      write_I   = (state == STREAM) && more_i && !I_ready;
      Out_LLR_A = '0;
      Out_Q_A   = '0;
      Out_LLR_I = '0;
      Out_Q_I   = '0;
      if (write_A) begin
         Out_LLR_A = mem_llr_a[rd_a];
         Out_Q_A   = mem_q_a[rd_a];
      end
      if (write_I) begin
         Out_LLR_I = mem_llr_i[rd_i];
         Out_Q_I   = mem_q_i[rd_i];
      end
   end

   // List storage carries data only; it needs no reset because counts gate every read.
   always_ff @(posedge clk) begin
      if (load_a) begin
         mem_llr_a[cnt_a] <= load_llr;
         mem_q_a[cnt_a]   <= load_q;
      end
      if (load_i) begin
         mem_llr_i[cnt_i] <= load_llr;
         mem_q_i[cnt_i]   <= load_q;
      end
   end

   always_ff @(posedge clk or negedge force_reset_n) begin
      if (!force_reset_n) begin
         state    <= IDLE;
         cnt_a    <= '0;
         cnt_i    <= '0;
         rd_a     <= '0;
         rd_i     <= '0;
         prev_a   <= '0;
         prev_i   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         load_err <= 1'b0;
         sort_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_a) begin
                  cnt_a  <= cnt_a + ONE;
                  prev_a <= load_llr;
               end
               if (load_i) begin
                  cnt_i  <= cnt_i + ONE;
                  prev_i <= load_llr;
               end
               // start clears the sticky flags; a same-cycle load can still raise them.
               if (start) begin
                  state    <= STREAM;
                  busy     <= 1'b1;
                  load_err <= drop;
                  sort_err <= misorder;
               end else begin
                  load_err <= load_err | drop;
                  sort_err <= sort_err | misorder;
               end
            end
            STREAM: begin
               if (write_A) rd_a <= rd_a + ONE;
               if (write_I) rd_i <= rd_i + ONE;
               if (load_en) load_err <= 1'b1;
               if (stream_end) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               if (load_en) load_err <= 1'b1;
               cnt_a  <= '0;
               cnt_i  <= '0;
               rd_a   <= '0;
               rd_i   <= '0;
               prev_a <= '0;
               prev_i <= '0;
               done   <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cn_list_feeder.sv
// Directed bench for cn_list_feeder: each task drives one scenario and checks
// the A/I channels and status flags cycle by cycle against hand-derived tables.
module tb_cn_list_feeder;

   logic       clk = 1'b0;
   logic       force_reset_n;
   logic       load_en, load_sel, start, A_ready, I_ready;
   logic [6:0] load_llr;
   logic [5:0] load_q;
   logic       write_A, write_I, busy, done, load_err, sort_err;
   logic [6:0] Out_LLR_A, Out_LLR_I;
   logic [5:0] Out_Q_A, Out_Q_I;

   int vectors = 0;
   int miscompares = 0;

   cn_list_feeder dut (
      .clk(clk), .force_reset_n(force_reset_n),
      .load_en(load_en), .load_sel(load_sel), .load_llr(load_llr), .load_q(load_q),
      .start(start), .A_ready(A_ready), .I_ready(I_ready),
      .write_A(write_A), .Out_LLR_A(Out_LLR_A), .Out_Q_A(Out_Q_A),
      .write_I(write_I), .Out_LLR_I(Out_LLR_I), .Out_Q_I(Out_Q_I),
      .busy(busy), .done(done), .load_err(load_err), .sort_err(sort_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic sel, input int llr, input int q);
      load_en  = 1'b1;
      load_sel = sel;
      load_llr = 7'(llr);
      load_q   = 6'(q);
      tick();
      load_en  = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      force_reset_n = 1'b1;
      #2 force_reset_n = 1'b0;
      #1;
      vectors++;
      if ({write_A, Out_LLR_A, Out_Q_A, write_I, Out_LLR_I, Out_Q_I,
           busy, done, load_err, sort_err} !== 32'd0)
         begin
            miscompares++;
            $display("FAIL reset_outputs got wA=%b wI=%b busy=%b done=%b lerr=%b serr=%b want all 0",
                     write_A, write_I, busy, done, load_err, sort_err);
         end
      #9 force_reset_n = 1'b1;
      tick();
      vectors++;
      if ({busy, done, write_A, write_I} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_release got busy=%b done=%b wA=%b wI=%b want 0",
                  busy, done, write_A, write_I);
      end
   endtask

   task automatic test_basic();
      logic [13:0] ea [5] = '{{1'b1,7'd0,6'd3}, {1'b1,7'd2,6'd7}, {1'b1,7'd5,6'd1}, 14'd0, 14'd0};
      logic [13:0] ei [5] = '{{1'b1,7'd1,6'd4}, {1'b1,7'd4,6'd2}, 14'd0, 14'd0, 14'd0};
      logic        ed [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_load(1'b0, 0, 3);
      do_load(1'b0, 2, 7);
      do_load(1'b0, 5, 1);
      do_load(1'b1, 1, 4);
      do_load(1'b1, 4, 2);
      pulse_start();
      for (int c = 0; c < 5; c++) begin
         vectors++;
         if ({write_A, Out_LLR_A, Out_Q_A} !== ea[c]) begin
            miscompares++;
            $display("FAIL basic_a cyc %0d got %h want %h", c, {write_A, Out_LLR_A, Out_Q_A}, ea[c]);
         end
         vectors++;
         if ({write_I, Out_LLR_I, Out_Q_I} !== ei[c]) begin
            miscompares++;
            $display("FAIL basic_i cyc %0d got %h want %h", c, {write_I, Out_LLR_I, Out_Q_I}, ei[c]);
         end
         vectors++;
         if ({busy, done} !== {1'b1, ed[c]}) begin
            miscompares++;
            $display("FAIL basic_status cyc %0d got busy=%b done=%b want 1 %b", c, busy, done, ed[c]);
         end
         tick();
      end
      vectors++;
      if ({busy, done, load_err, sort_err} !== 4'b0000) begin
         miscompares++;
         $display("FAIL basic_end got busy=%b done=%b lerr=%b serr=%b want 0000",
                  busy, done, load_err, sort_err);
      end
   endtask

   task automatic test_backpressure();
      logic [13:0] ea [4] = '{{1'b1,7'd10,6'd1}, {1'b1,7'd11,6'd2}, 14'd0, 14'd0};
      logic        ra [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic        ed [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) do_load(1'b0, 10 + k, 1 + k);
      pulse_start();
      for (int c = 0; c < 4; c++) begin
         A_ready = ra[c];
         #1;
         vectors++;
         if ({write_A, Out_LLR_A, Out_Q_A, done} !== {ea[c], ed[c]}) begin
            miscompares++;
            $display("FAIL bp cyc %0d got %h done=%b want %h done=%b",
                     c, {write_A, Out_LLR_A, Out_Q_A}, done, ea[c], ed[c]);
         end
         tick();
      end
      A_ready = 1'b0;
      #1;
      vectors++;
      if ({busy, write_A, Out_LLR_A} !== 9'd0) begin
         miscompares++;
         $display("FAIL bp_idle got busy=%b wA=%b llr=%0d want 0", busy, write_A, Out_LLR_A);
      end
   endtask

   task automatic test_ready_resume();
      logic [13:0] ea [6] = '{{1'b1,7'd1,6'd1}, 14'd0, {1'b1,7'd2,6'd2}, {1'b1,7'd3,6'd3}, 14'd0, 14'd0};
      logic [13:0] ei [6] = '{{1'b1,7'd0,6'd5}, {1'b1,7'd1,6'd6}, {1'b1,7'd2,6'd7},
                              {1'b1,7'd3,6'd8}, 14'd0, 14'd0};
      logic        ra [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        ed [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 1; k <= 3; k++) do_load(1'b0, k, k);
      for (int k = 0; k < 4; k++) do_load(1'b1, k, 5 + k);
      pulse_start();
      for (int c = 0; c < 6; c++) begin
         A_ready = ra[c];
         #1;
         vectors++;
         if ({write_A, Out_LLR_A, Out_Q_A, write_I, Out_LLR_I, Out_Q_I, done} !== {ea[c], ei[c], ed[c]}) begin
            miscompares++;
            $display("FAIL resume cyc %0d got A=%h I=%h done=%b want A=%h I=%h done=%b",
                     c, {write_A, Out_LLR_A, Out_Q_A}, {write_I, Out_LLR_I, Out_Q_I}, done,
                     ea[c], ei[c], ed[c]);
         end
         tick();
      end
      A_ready = 1'b0;
   endtask

   task automatic test_empty_start();
      start = 1'b1;
      tick();
      start    = 1'b0;
      load_en  = 1'b1;
      load_sel = 1'b0;
      load_llr = 7'd50;
      load_q   = 6'd9;
      vectors++;
      if ({write_A, write_I, busy, done} !== 4'b0010) begin
         miscompares++;
         $display("FAIL empty_stream got wA=%b wI=%b busy=%b done=%b want 0 0 1 0",
                  write_A, write_I, busy, done);
      end
      tick();
      load_en = 1'b0;
      vectors++;
      if ({busy, done, load_err} !== 3'b111) begin
         miscompares++;
         $display("FAIL empty_done got busy=%b done=%b lerr=%b want 1 1 1", busy, done, load_err);
      end
      tick();
      vectors++;
      if ({busy, done} !== 2'b00) begin
         miscompares++;
         $display("FAIL empty_idle got busy=%b done=%b want 0 0", busy, done);
      end
      pulse_start();
      vectors++;
      if ({write_A, write_I, Out_LLR_A} !== 9'd0) begin
         miscompares++;
         $display("FAIL ignored_load got wA=%b wI=%b llr=%0d want 0", write_A, write_I, Out_LLR_A);
      end
      tick();
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL ignored_load_done got %b want 1", done);
      end
      tick();
   endtask

   task automatic test_sort_error();
      do_load(1'b0, 3, 11);
      vectors++;
      if (sort_err !== 1'b0) begin
         miscompares++;
         $display("FAIL sort_first got %b want 0", sort_err);
      end
      do_load(1'b0, 1, 12);
      vectors++;
      if (sort_err !== 1'b1) begin
         miscompares++;
         $display("FAIL sort_flag got %b want 1", sort_err);
      end
      pulse_start();
      vectors++;
      if ({sort_err, write_A, Out_LLR_A, Out_Q_A} !== {1'b0, 1'b1, 7'd3, 6'd11}) begin
         miscompares++;
         $display("FAIL sort_stream0 got serr=%b wA=%b llr=%0d q=%0d want 0 1 3 11",
                  sort_err, write_A, Out_LLR_A, Out_Q_A);
      end
      tick();
      vectors++;
      if ({write_A, Out_LLR_A, Out_Q_A} !== {1'b1, 7'd1, 6'd12}) begin
         miscompares++;
         $display("FAIL sort_stream1 got wA=%b llr=%0d q=%0d want 1 1 12", write_A, Out_LLR_A, Out_Q_A);
      end
      tick();
      tick();
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL sort_done got %b want 1", done);
      end
      tick();
   endtask

   task automatic test_overflow();
      int writes = 0;
      for (int k = 0; k < 31; k++) do_load(1'b0, k, k);
      vectors++;
      if (load_err !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_before got %b want 0", load_err);
      end
      do_load(1'b0, 99, 63);
      vectors++;
      if (load_err !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_flag got %b want 1", load_err);
      end
      pulse_start();
      vectors++;
      if (load_err !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_clear got %b want 0", load_err);
      end
      for (int c = 0; c < 31; c++) begin
         vectors++;
         if ({write_A, Out_LLR_A, Out_Q_A} !== {1'b1, 7'(c), 6'(c)}) begin
            miscompares++;
            $display("FAIL ovf_entry %0d got wA=%b llr=%0d q=%0d want 1 %0d %0d",
                     c, write_A, Out_LLR_A, Out_Q_A, c, c);
         end
         if (write_A === 1'b1) writes++;
         tick();
      end
      vectors++;
      if (write_A !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_extra got wA=%b llr=%0d want 0", write_A, Out_LLR_A);
      end
      tick();
      vectors++;
      if ({done, writes} !== {1'b1, 32'd31}) begin
         miscompares++;
         $display("FAIL ovf_count got done=%b writes=%0d want 1 31", done, writes);
      end
      tick();
   endtask

   task automatic test_reset_mid_stream();
      do_load(1'b0, 7, 1);
      do_load(1'b0, 8, 2);
      do_load(1'b0, 9, 3);
      pulse_start();
      vectors++;
      if ({write_A, Out_LLR_A} !== {1'b1, 7'd7}) begin
         miscompares++;
         $display("FAIL rst_first got wA=%b llr=%0d want 1 7", write_A, Out_LLR_A);
      end
      tick();
      force_reset_n = 1'b0;
      #1;
      vectors++;
      if ({write_A, Out_LLR_A, Out_Q_A, write_I, busy, done, load_err, sort_err} !== 20'd0) begin
         miscompares++;
         $display("FAIL rst_async got wA=%b llr=%0d q=%0d busy=%b done=%b want 0",
                  write_A, Out_LLR_A, Out_Q_A, busy, done);
      end
      #2 force_reset_n = 1'b1;
      tick();
      pulse_start();
      vectors++;
      if ({write_A, write_I, busy, done} !== 4'b0010) begin
         miscompares++;
         $display("FAIL rst_restart got wA=%b wI=%b busy=%b done=%b want 0 0 1 0",
                  write_A, write_I, busy, done);
      end
      tick();
      vectors++;
      if ({write_A, done} !== 2'b01) begin
         miscompares++;
         $display("FAIL rst_done got wA=%b done=%b want 0 1", write_A, done);
      end
      tick();
   endtask

   initial begin
      load_en  = 1'b0;
      load_sel = 1'b0;
      load_llr = '0;
      load_q   = '0;
      start    = 1'b0;
      A_ready  = 1'b0;
      I_ready  = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_ready_resume();
      test_empty_start();
      test_sort_error();
      test_overflow();
      test_reset_mid_stream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
